cb_quant_zigzag: RTL and testbench

CB_QUANT_ZIGZAG -- requirements
Module: cb_quant_zigzag

---
 rtl/cb_quant_pkg.sv | 50 +++++
 rtl/cb_quant_mul.sv | 36 +++
 rtl/cb_quant_zigzag.sv | 130 +++++++++++++
 tb/tb_cb_quant_zigzag.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cb_quant_pkg.sv
// cb_quant_pkg -- shared definitions for the Cb quantizer / zigzag emitter.
//   state_e    : emitter FSM state
//   COEF_W_DEF : default signed coefficient width
//   Q_CHROMA   : standard JPEG chrominance quantization table, raster order
//   R_RECIP    : round(4096 / Q) per raster position, derived from Q_CHROMA
//   ZZ_RASTER  : zigzag position -> raster index {row[2:0], col[2:0]}
package cb_quant_pkg;

    localparam int COEF_W_DEF = 11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

    localparam logic [0:63][6:0] Q_CHROMA = '{
        7'd17, 7'd18, 7'd24, 7'd47, 7'd99, 7'd99, 7'd99, 7'd99,
        7'd18, 7'd21, 7'd26, 7'd66, 7'd99, 7'd99, 7'd99, 7'd99,
        7'd24, 7'd26, 7'd56, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99,
        7'd47, 7'd66, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99,
        7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99,
        7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99,
        7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99,
        7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99
    };

    typedef logic [0:63][7:0] recip_tab_t;

    // Largest reciprocal is round(4096/17) = 241, so 8 bits suffice.
    function automatic recip_tab_t gen_recip();
        recip_tab_t t;
        for (int i = 0; i < 64; i++)
            t[i] = 8'((4096 + int'(Q_CHROMA[i]) / 2) / int'(Q_CHROMA[i]));
        return t;
    endfunction

    localparam recip_tab_t R_RECIP = gen_recip();

    localparam logic [0:63][5:0] ZZ_RASTER = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

endpackage

// File: rtl/cb_quant_mul.sv
// cb_quant_mul -- combinational reciprocal quantizer for one coefficient.
//   z     : signed coefficient
//   recip : round(4096/Q) for this coefficient's position
//   q     : sign(z) * ((|z| * recip + RND) >> RECIP_SHIFT)
// Optional feature macro CB_QUANT_ROUND_EN: RND = 2^(RECIP_SHIFT-1), giving
// round-half-away-from-zero; otherwise RND = 0 (truncate toward zero).
module cb_quant_mul #(
    parameter int COEF_W      = 11,
    parameter int RECIP_SHIFT = 12
) (
    input  logic signed [COEF_W-1:0] z,
    input  logic        [7:0]        recip,
    output logic signed [COEF_W-1:0] q
);
    localparam int PW = 32;

`ifdef CB_QUANT_ROUND_EN
    localparam logic [PW-1:0] RND = PW'(1) << (RECIP_SHIFT - 1);
`else
    localparam logic [PW-1:0] RND = '0;
`endif

    logic              neg;
    logic [COEF_W-1:0] z_u, mag, mag_q;
    logic [PW-1:0]     prod;

    // Working on the magnitude keeps rounding symmetric about zero.
    // |-2^(COEF_W-1)| still fits as an unsigned COEF_W value.
    assign neg   = z[COEF_W-1];
    assign z_u   = z;
    assign mag   = neg ? (~z_u + 1'b1) : z_u;
    assign prod  = PW'(mag) * PW'(recip) + RND;
    assign mag_q = COEF_W'(prod >> RECIP_SHIFT);
    assign q     = neg ? $signed(~mag_q + 1'b1) : $signed(mag_q);

endmodule

// File: rtl/cb_quant_zigzag.sv
// cb_quant_zigzag -- captures an 8x8 Cb DCT block and streams quantized
// coefficients in JPEG zigzag order over a valid/ready handshake.
//   clk, rst (async, active low)
//   enable        : block-available level from the DCT; rising edge = block start
//   Z11..Z88_final: signed coefficients, row r column c as Zrc_final
//   out_ready     : downstream accepts the current beat
//   q_out/q_valid/q_index/q_last : output beat (zigzag index 0..63)
//   busy          : a block is being emitted
//   drop          : one-cycle pulse when a block start is discarded
// Optional feature macro CB_QUANT_ROUND_EN (rounding in cb_quant_mul).
module cb_quant_zigzag
    import cb_quant_pkg::*;
#(
    parameter int COEF_W      = COEF_W_DEF,
    parameter int RECIP_SHIFT = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic signed [COEF_W-1:0] Z11_final, Z12_final, Z13_final, Z14_final,
                                     Z15_final, Z16_final, Z17_final, Z18_final,
    input  logic signed [COEF_W-1:0] Z21_final, Z22_final, Z23_final, Z24_final,
                                     Z25_final, Z26_final, Z27_final, Z28_final,
    input  logic signed [COEF_W-1:0] Z31_final, Z32_final, Z33_final, Z34_final,
                                     Z35_final, Z36_final, Z37_final, Z38_final,
    input  logic signed [COEF_W-1:0] Z41_final, Z42_final, Z43_final, Z44_final,
                                     Z45_final, Z46_final, Z47_final, Z48_final,
    input  logic signed [COEF_W-1:0] Z51_final, Z52_final, Z53_final, Z54_final,
                                     Z55_final, Z56_final, Z57_final, Z58_final,
    input  logic signed [COEF_W-1:0] Z61_final, Z62_final, Z63_final, Z64_final,
                                     Z65_final, Z66_final, Z67_final, Z68_final,
    input  logic signed [COEF_W-1:0] Z71_final, Z72_final, Z73_final, Z74_final,
                                     Z75_final, Z76_final, Z77_final, Z78_final,
    input  logic signed [COEF_W-1:0] Z81_final, Z82_final, Z83_final, Z84_final,
                                     Z85_final, Z86_final, Z87_final, Z88_final,
    input  logic out_ready,
    output logic signed [COEF_W-1:0] q_out,
    output logic       q_valid,
    output logic [5:0] q_index,
    output logic       q_last,
    output logic       busy,
    output logic       drop
);

    logic [63:0][COEF_W-1:0] z_in, bank;

    // Raster packing: z_in[r*8+c] = Z{r+1}{c+1}_final.
    assign z_in = {Z88_final, Z87_final, Z86_final, Z85_final, Z84_final, Z83_final, Z82_final, Z81_final,
                   Z78_final, Z77_final, Z76_final, Z75_final, Z74_final, Z73_final, Z72_final, Z71_final,
                   Z68_final, Z67_final, Z66_final, Z65_final, Z64_final, Z63_final, Z62_final, Z61_final,
                   Z58_final, Z57_final, Z56_final, Z55_final, Z54_final, Z53_final, Z52_final, Z51_final,
                   Z48_final, Z47_final, Z46_final, Z45_final, Z44_final, Z43_final, Z42_final, Z41_final,
                   Z38_final, Z37_final, Z36_final, Z35_final, Z34_final, Z33_final, Z32_final, Z31_final,
                   Z28_final, Z27_final, Z26_final, Z25_final, Z24_final, Z23_final, Z22_final, Z21_final,
                   Z18_final, Z17_final, Z16_final, Z15_final, Z14_final, Z13_final, Z12_final, Z11_final};

    state_e                    state;
    logic                      enable_d, start, xfer, last_xfer, capture;
    logic [5:0]                nxt_idx;
    logic signed [COEF_W-1:0]  mul_z, mul_q;
    logic [7:0]                mul_r;

    assign start     = enable & ~enable_d;
    assign xfer      = q_valid & out_ready;
    assign last_xfer = xfer & q_last;
    // A start coinciding with the final transfer chains straight into the next block.
    assign capture   = start & ((state == ST_IDLE) | last_xfer);
    assign nxt_idx   = q_index + 6'd1;

    // On capture the bank is not loaded yet, so the DC term comes straight
    // from the inputs; this lets beat 0 appear the cycle after capture.
    always_comb begin
        mul_z = bank[ZZ_RASTER[nxt_idx]];
        mul_r = R_RECIP[ZZ_RASTER[nxt_idx]];
        if (capture) begin
            mul_z = z_in[0];
            mul_r = R_RECIP[0];
        end
    end

    cb_quant_mul #(
        .COEF_W      (COEF_W),
        .RECIP_SHIFT (RECIP_SHIFT)
    ) u_mul (
        .z     (mul_z),
        .recip (mul_r),
        .q     (mul_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            enable_d <= 1'b0;
            q_out    <= '0;
            q_valid  <= 1'b0;
            q_index  <= '0;
            q_last   <= 1'b0;
            busy     <= 1'b0;
            drop     <= 1'b0;
        end else begin
            enable_d <= enable;
            drop     <= start & (state == ST_EMIT) & ~last_xfer;
            if (capture) begin
                state   <= ST_EMIT;
                busy    <= 1'b1;
                q_valid <= 1'b1;
                q_index <= '0;
                q_last  <= 1'b0;
                q_out   <= mul_q;
            end else if (last_xfer) begin
                state   <= ST_IDLE;
                busy    <= 1'b0;
                q_valid <= 1'b0;
                q_index <= '0;
                q_last  <= 1'b0;
                q_out   <= '0;
            end else if (xfer) begin
                q_index <= nxt_idx;
                q_last  <= (nxt_idx == 6'd63);
                q_out   <= mul_q;
            end
        end
    end

    // Data-only storage; contents are meaningless until the first capture.
    always_ff @(posedge clk) begin
        if (capture) bank <= z_in;
    end

endmodule

// File: tb/tb_cb_quant_zigzag.sv
module tb_cb_quant_zigzag;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b0;
    logic out_ready = 1'b1;
    logic signed [10:0] z [64];
    logic signed [10:0] q_out;
    logic       q_valid;
    logic [5:0] q_index;
    logic       q_last, busy, drop;

    int checks = 0;
    int failures = 0;
    int qtab [64];
    int zz [64];
    int exp_q [64];

`ifdef CB_QUANT_ROUND_EN
    localparam int RND = 2048;
    localparam int H_DC1 = 1, H0 = 1, H1 = 2, H2 = 8, H3 = 11, H63 = 10;
`else
    localparam int RND = 0;
    localparam int H_DC1 = 0, H0 = 0, H1 = 1, H2 = 7, H3 = 10, H63 = 9;
`endif

    always #5 clk = ~clk;

    cb_quant_zigzag dut (
        .clk(clk), .rst(rst), .enable(enable),
        .Z11_final(z[0]),  .Z12_final(z[1]),  .Z13_final(z[2]),  .Z14_final(z[3]),
        .Z15_final(z[4]),  .Z16_final(z[5]),  .Z17_final(z[6]),  .Z18_final(z[7]),
        .Z21_final(z[8]),  .Z22_final(z[9]),  .Z23_final(z[10]), .Z24_final(z[11]),
        .Z25_final(z[12]), .Z26_final(z[13]), .Z27_final(z[14]), .Z28_final(z[15]),
        .Z31_final(z[16]), .Z32_final(z[17]), .Z33_final(z[18]), .Z34_final(z[19]),
        .Z35_final(z[20]), .Z36_final(z[21]), .Z37_final(z[22]), .Z38_final(z[23]),
        .Z41_final(z[24]), .Z42_final(z[25]), .Z43_final(z[26]), .Z44_final(z[27]),
        .Z45_final(z[28]), .Z46_final(z[29]), .Z47_final(z[30]), .Z48_final(z[31]),
        .Z51_final(z[32]), .Z52_final(z[33]), .Z53_final(z[34]), .Z54_final(z[35]),
        .Z55_final(z[36]), .Z56_final(z[37]), .Z57_final(z[38]), .Z58_final(z[39]),
        .Z61_final(z[40]), .Z62_final(z[41]), .Z63_final(z[42]), .Z64_final(z[43]),
        .Z65_final(z[44]), .Z66_final(z[45]), .Z67_final(z[46]), .Z68_final(z[47]),
        .Z71_final(z[48]), .Z72_final(z[49]), .Z73_final(z[50]), .Z74_final(z[51]),
        .Z75_final(z[52]), .Z76_final(z[53]), .Z77_final(z[54]), .Z78_final(z[55]),
        .Z81_final(z[56]), .Z82_final(z[57]), .Z83_final(z[58]), .Z84_final(z[59]),
        .Z85_final(z[60]), .Z86_final(z[61]), .Z87_final(z[62]), .Z88_final(z[63]),
        .out_ready(out_ready),
        .q_out(q_out), .q_valid(q_valid), .q_index(q_index), .q_last(q_last),
        .busy(busy), .drop(drop)
    );

    function automatic int model_q(input int zv, input int p);
        int r, mag, res;
        r   = (4096 + qtab[p] / 2) / qtab[p];
        mag = (zv < 0) ? -zv : zv;
        res = (mag * r + RND) / 4096;
        return (zv < 0) ? -res : res;
    endfunction

    task automatic build_tables();
        int r, c;
        for (int i = 0; i < 64; i++) qtab[i] = 99;
        qtab[0]  = 17; qtab[1]  = 18; qtab[2]  = 24; qtab[3]  = 47;
        qtab[8]  = 18; qtab[9]  = 21; qtab[10] = 26; qtab[11] = 66;
        qtab[16] = 24; qtab[17] = 26; qtab[18] = 56;
        qtab[24] = 47; qtab[25] = 66;
        r = 0; c = 0;
        for (int k = 0; k < 64; k++) begin
            zz[k] = r * 8 + c;
            if (((r + c) % 2) == 0) begin
                if (c == 7) r++;
                else if (r == 0) c++;
                else begin r--; c++; end
            end else begin
                if (r == 7) c++;
                else if (c == 0) r++;
                else begin r++; c--; end
            end
        end
    endtask

    task automatic clear_z();
        for (int p = 0; p < 64; p++) z[p] = '0;
    endtask

    task automatic load_ramp();
        for (int p = 0; p < 64; p++) z[p] = 11'(15 * (p + 1));
        z[63] = 11'sd990;
        for (int k = 0; k < 64; k++) exp_q[k] = model_q(int'(z[zz[k]]), zz[k]);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!q_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        clear_z();
        rst = 1'b0; enable = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({q_valid, q_last, busy, drop} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got=%b want=0000", {q_valid, q_last, busy, drop});
        end
        checks++;
        if (q_out !== 11'sd0 || q_index !== 6'd0) begin
            failures++;
            $display("FAIL reset_data got q=%0d idx=%0d want 0 0", q_out, q_index);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (q_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got v=%b busy=%b want 0 0", q_valid, busy);
        end
    endtask

    task automatic test_dc();
        int e;
        clear_z();
        z[0] = 11'sd1020;
        pulse_start();
        for (int k = 0; k < 64; k++) begin
            e = (k == 0) ? 60 : 0;
            checks++;
            if (q_valid !== 1'b1 || q_index !== 6'(k) || q_last !== (k == 63) || q_out !== 11'(e)) begin
                failures++;
                $display("FAIL dc_beat k=%0d got v=%b idx=%0d last=%b q=%0d want idx=%0d q=%0d",
                         k, q_valid, q_index, q_last, q_out, k, e);
            end
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b0 || q_valid !== 1'b0) begin
            failures++;
            $display("FAIL dc_done got busy=%b v=%b want 0 0", busy, q_valid);
        end
    endtask

    task automatic test_sign();
        bit ok;
        clear_z();
        z[0] = -11'sd1020;
        z[1] = 11'sd9;
        pulse_start();
        checks++;
        if (q_index !== 6'd0 || q_out !== 11'(-60)) begin
            failures++;
            $display("FAIL sign_dc got idx=%0d q=%0d want 0 -60", q_index, q_out);
        end
        @(negedge clk);
        checks++;
        if (q_index !== 6'd1 || q_out !== 11'(H_DC1)) begin
            failures++;
            $display("FAIL sign_z12 got idx=%0d q=%0d want 1 %0d", q_index, q_out, H_DC1);
        end
        drain(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL sign_drain got timeout want q_valid low");
        end
    endtask

    task automatic test_order();
        load_ramp();
        pulse_start();
        for (int k = 0; k < 64; k++) begin
            checks++;
            if (q_valid !== 1'b1 || q_index !== 6'(k) || q_last !== (k == 63) || q_out !== 11'(exp_q[k])) begin
                failures++;
                $display("FAIL order_beat k=%0d got idx=%0d last=%b q=%0d want q=%0d",
                         k, q_index, q_last, q_out, exp_q[k]);
            end
            if (k == 0 || k == 1 || k == 2 || k == 3 || k == 63) begin
                int h;
                h = (k == 0) ? H0 : (k == 1) ? H1 : (k == 2) ? H2 : (k == 3) ? H3 : H63;
                checks++;
                if (q_out !== 11'(h)) begin
                    failures++;
                    $display("FAIL order_hand k=%0d got q=%0d want %0d", k, q_out, h);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (q_valid !== 1'b0) begin
            failures++;
            $display("FAIL order_done got v=%b want 0", q_valid);
        end
    endtask

    task automatic test_stall();
        int ek, stall, beats;
        load_ramp();
        pulse_start();
        ek = 0; stall = 0; beats = 0;
        for (int cyc = 0; cyc < 200 && ek < 64; cyc++) begin
            checks++;
            if (q_valid !== 1'b1 || q_index !== 6'(ek) || q_last !== (ek == 63) || q_out !== 11'(exp_q[ek])) begin
                failures++;
                $display("FAIL stall_beat cyc=%0d got idx=%0d q=%0d want idx=%0d q=%0d",
                         cyc, q_index, q_out, ek, exp_q[ek]);
            end
            if (ek == 10 && stall < 5) begin
                out_ready = 1'b0;
                stall++;
            end else begin
                out_ready = 1'b1;
                ek++;
                beats++;
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        checks++;
        if (beats != 64 || stall != 5 || q_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_total got beats=%0d stalls=%0d v=%b want 64 5 0", beats, stall, q_valid);
        end
    endtask

    task automatic test_drop_chain();
        bit ok;
        load_ramp();
        pulse_start();
        for (int k = 0; k < 64; k++) begin
            checks++;
            if (q_valid !== 1'b1 || q_index !== 6'(k) || q_out !== 11'(exp_q[k])) begin
                failures++;
                $display("FAIL drop_beat k=%0d got idx=%0d q=%0d want q=%0d", k, q_index, q_out, exp_q[k]);
            end
            if (k == 20) begin
                enable = 1'b1;
                clear_z();
                z[0] = 11'sd1020;
            end
            if (k == 21) begin
                enable = 1'b0;
                checks++;
                if (drop !== 1'b1) begin
                    failures++;
                    $display("FAIL drop_pulse got %b want 1", drop);
                end
            end
            if (k == 22) begin
                checks++;
                if (drop !== 1'b0) begin
                    failures++;
                    $display("FAIL drop_clear got %b want 0", drop);
                end
            end
            if (k == 63) enable = 1'b1;
            @(negedge clk);
        end
        enable = 1'b0;
        checks++;
        if (q_valid !== 1'b1 || q_index !== 6'd0 || q_out !== 11'sd60 || busy !== 1'b1 || drop !== 1'b0) begin
            failures++;
            $display("FAIL chain_start got v=%b idx=%0d q=%0d busy=%b drop=%b want 1 0 60 1 0",
                     q_valid, q_index, q_out, busy, drop);
        end
        @(negedge clk);
        checks++;
        if (q_index !== 6'd1 || q_out !== 11'sd0) begin
            failures++;
            $display("FAIL chain_beat1 got idx=%0d q=%0d want 1 0", q_index, q_out);
        end
        drain(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL chain_drain got timeout want q_valid low");
        end
    endtask

    task automatic test_reset_mid();
        load_ramp();
        pulse_start();
        repeat (30) @(negedge clk);
        checks++;
        if (q_index !== 6'd30) begin
            failures++;
            $display("FAIL rmid_pos got idx=%0d want 30", q_index);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (q_valid !== 1'b0 || q_index !== 6'd0 || q_out !== 11'sd0 || q_last !== 1'b0 ||
            busy !== 1'b0 || drop !== 1'b0) begin
            failures++;
            $display("FAIL rmid_async got v=%b idx=%0d q=%0d last=%b busy=%b drop=%b want all 0",
                     q_valid, q_index, q_out, q_last, busy, drop);
        end
        @(negedge clk);
        rst = 1'b1;
        pulse_start();
        for (int k = 0; k < 64; k++) begin
            checks++;
            if (q_valid !== 1'b1 || q_index !== 6'(k) || q_last !== (k == 63) || q_out !== 11'(exp_q[k])) begin
                failures++;
                $display("FAIL rmid_beat k=%0d got idx=%0d q=%0d want q=%0d", k, q_index, q_out, exp_q[k]);
            end
            @(negedge clk);
        end
        checks++;
        if (q_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rmid_done got v=%b busy=%b want 0 0", q_valid, busy);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        build_tables();
        test_reset();
        test_dc();
        test_sign();
        test_order();
        test_stall();
        test_drop_chain();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
